// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder: detects a host start pulse on the open-drain line,
// then drives the response preamble and a 40-bit frame with standard DHT11 pulse widths.
module dht11_responder #(
  parameter int START_MIN  = 18000,
  parameter int RESP_DELAY = 30,
  parameter int RESP_LOW   = 80,
  parameter int RESP_HIGH  = 80,
  parameter int BIT_LOW    = 50,
  parameter int ZERO_HIGH  = 26,
  parameter int ONE_HIGH   = 70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dat_i,
  output logic       dat_oe,
  input  logic [7:0] humid_int,
  input  logic [7:0] humid_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       inject_err,
  output logic       busy,
  output logic       frame_done,
  output logic       short_start,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MEAS  = 3'd1;
  localparam logic [2:0] DELAY = 3'd2;
  localparam logic [2:0] RLOW  = 3'd3;
  localparam logic [2:0] RHIGH = 3'd4;
  localparam logic [2:0] BLOW  = 3'd5;
  localparam logic [2:0] BHIGH = 3'd6;

  localparam logic [14:0] START_LC   = 15'(START_MIN);
  localparam logic [15:0] DELAY_LAST = 16'(RESP_DELAY - 1);
  localparam logic [15:0] RLOW_LAST  = 16'(RESP_LOW - 1);
  localparam logic [15:0] RHIGH_LAST = 16'(RESP_HIGH - 1);
  localparam logic [15:0] BLOW_LAST  = 16'(BIT_LOW - 1);
  localparam logic [15:0] ZERO_LAST  = 16'(ZERO_HIGH - 1);
  localparam logic [15:0] ONE_LAST   = 16'(ONE_HIGH - 1);

  logic        sync_q;
  logic        ds;
  logic        ds_prev;
  logic [2:0]  state;
  logic [14:0] lc;
  logic [15:0] cnt;
  logic [15:0] phase_last;
  logic        phase_end;
  logic        timed;
  logic [5:0]  bit_idx;
  logic [39:0] frame;
  logic [7:0]  sum;
  logic [7:0]  chk;
  logic        rise;

  assign state_dbg = state;
  assign rise      = ds & ~ds_prev;
  assign sum       = humid_int + humid_dec + temp_int + temp_dec;
  assign chk       = {sum[7:1], sum[0] ^ inject_err};

  // Length of the current timed phase; BHIGH width follows the bit at the frame MSB.
  always_comb begin
    phase_last = '0;
    timed      = 1'b1;
    case (state)
      DELAY:   phase_last = DELAY_LAST;
      RLOW:    phase_last = RLOW_LAST;
      RHIGH:   phase_last = RHIGH_LAST;
      BLOW:    phase_last = BLOW_LAST;
      BHIGH:   phase_last = frame[39] ? ONE_LAST : ZERO_LAST;
      default: timed = 1'b0;
    endcase
  end

  assign phase_end = (cnt == phase_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Synchronizer resets to the idle (pulled-up) level so reset never looks like a start.
      sync_q      <= 1'b1;
      ds          <= 1'b1;
      ds_prev     <= 1'b1;
      state       <= IDLE;
      lc          <= '0;
      cnt         <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      dat_oe      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      short_start <= 1'b0;
    end else begin
      sync_q      <= dat_i;
      ds          <= sync_q;
      ds_prev     <= ds;
      frame_done  <= 1'b0;
      short_start <= 1'b0;
      cnt         <= (timed && !phase_end) ? cnt + 16'd1 : '0;
      case (state)
        IDLE: begin
          if (!ds) begin
            state <= MEAS;
            lc    <= 15'd1;
          end
        end
        MEAS: begin
          if (rise) begin
            if (lc >= START_LC) begin
              frame   <= {humid_int, humid_dec, temp_int, temp_dec, chk};
              bit_idx <= '0;
              busy    <= 1'b1;
              state   <= DELAY;
            end else begin
              short_start <= 1'b1;
              state       <= IDLE;
            end
          end else if (!ds && lc < START_LC) begin
            lc <= lc + 15'd1;
          end
        end
        DELAY: begin
          if (phase_end) begin
            state  <= RLOW;
            dat_oe <= 1'b1;
          end
        end
        RLOW: begin
          if (phase_end) begin
            state  <= RHIGH;
            dat_oe <= 1'b0;
          end
        end
        RHIGH: begin
          if (phase_end) begin
            state  <= BLOW;
            dat_oe <= 1'b1;
          end
        end
        BLOW: begin
          if (phase_end) begin
            dat_oe <= 1'b0;
            if (bit_idx == 6'd40) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              lc         <= '0;
            end else begin
              state <= BHIGH;
            end
          end
        end
        BHIGH: begin
          if (phase_end) begin
            frame   <= {frame[38:0], 1'b0};
            bit_idx <= bit_idx + 6'd1;
            state   <= BLOW;
            dat_oe  <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          dat_oe <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: a segment-level waveform model predicts every output
// cycle, and a line decoder recovers the sent frame for literal payload checks.
module tb_dht11_responder;

  localparam int START_MIN = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       dat_i;
  logic       dat_oe;
  logic [7:0] humid_int, humid_dec, temp_int, temp_dec;
  logic       inject_err;
  logic       busy, frame_done, short_start;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle vector {busy, dat_oe, frame_done, short_start}; empty queue means all 0.
  logic [3:0]  exp_q[$];
  logic [39:0] exp_frame;
  bit          check_en = 1'b0;
  int          runs[$];
  int          zrun = 0;

  dht11_responder #(.START_MIN(START_MIN)) dut (
    .clk(clk), .rst(rst), .dat_i(dat_i), .dat_oe(dat_oe),
    .humid_int(humid_int), .humid_dec(humid_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .inject_err(inject_err), .busy(busy), .frame_done(frame_done),
    .short_start(short_start), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // Per-cycle compare against the model queue.
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst && check_en) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
      n_checks++;
      if ({busy, dat_oe, frame_done, short_start} !== e) begin
        n_fail++;
        if (n_fail < 30)
          $display("FAIL cycle_outputs @%0t: got %b, want %b (busy,oe,done,short)",
                   $time, {busy, dat_oe, frame_done, short_start}, e);
      end
    end
  end

  // Line decoder: lengths of released runs while busy.
  always @(negedge clk) begin
    if (rst) begin
      zrun = 0;
    end else if (busy && !dat_oe) begin
      zrun++;
    end else if (zrun != 0) begin
      runs.push_back(zrun);
      zrun = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic push_n(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Three cycles of synchronizer/edge latency, then the whole response as timed segments.
  task automatic push_frame(input logic [7:0] h1, input logic [7:0] h2, input logic [7:0] t1,
                            input logic [7:0] t2, input logic inj);
    logic [7:0] s;
    s = 8'(h1 + h2 + t1 + t2);
    s[0] = s[0] ^ inj;
    exp_frame = {h1, h2, t1, t2, s};
    push_n(4'b0000, 3);
    push_n(4'b1000, 30);
    push_n(4'b1100, 80);
    push_n(4'b1000, 80);
    for (int i = 39; i >= 0; i--) begin
      push_n(4'b1100, 50);
      push_n(4'b1000, exp_frame[i] ? 70 : 26);
    end
    push_n(4'b1100, 50);
    push_n(4'b0010, 1);
  endtask

  task automatic host_low(input int n);
    @(posedge clk); #1 dat_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_frame(input logic [7:0] h1, input logic [7:0] h2, input logic [7:0] t1,
                           input logic [7:0] t2, input logic inj, input int hold,
                           input bit disturb, output logic [39:0] cap);
    humid_int = h1; humid_dec = h2; temp_int = t1; temp_dec = t2; inject_err = inj;
    runs.delete();
    host_low(hold);
    push_frame(h1, h2, t1, t2, inj);
    dat_i = 1'b1;
    repeat (6) @(posedge clk);
    #1 inject_err = 1'b0;
    if (disturb) begin
      repeat (2000) begin
        @(posedge clk); #1;
        dat_i = 1'($urandom_range(0, 1));
        humid_int = 8'($urandom); humid_dec = 8'($urandom);
        temp_int = 8'($urandom); temp_dec = 8'($urandom);
        inject_err = 1'($urandom_range(0, 1));
      end
      dat_i = 1'b1;
      inject_err = 1'b0;
    end
    wait_drain(8000);
    cap = '0;
    check("run_count", 64'(runs.size()), 64'd42);
    if (runs.size() == 42) begin
      check("resp_delay_width", 64'(runs[0]), 64'd30);
      check("resp_high_width", 64'(runs[1]), 64'd80);
      for (int i = 0; i < 40; i++) cap[39 - i] = (runs[2 + i] > 48);
      check("decoded_frame", 64'(cap), 64'(exp_frame));
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [39:0] cap;
    rst = 1'b1; dat_i = 1'b1; inject_err = 1'b0;
    humid_int = '0; humid_dec = '0; temp_int = '0; temp_dec = '0;
    repeat (3) @(negedge clk);
    check("reset_dat_oe", 64'(dat_oe), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    check("reset_short_start", 64'(short_start), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    @(posedge clk); #1 rst = 1'b0; check_en = 1'b1;
    repeat (5) @(posedge clk);

    // Exact-minimum start with the reference payload.
    run_frame(8'h37, 8'h00, 8'h18, 8'h00, 1'b0, START_MIN, 1'b0, cap);
    check("payload_37_frame", 64'(cap), 64'h37_00_18_00_4F);
    check("payload_37_chk", 64'(cap[7:0]), 64'h4F);

    // Checksum wrap, then the same with the checksum fault injected.
    run_frame(8'hFF, 8'hFF, 8'hFF, 8'h03, 1'b0, START_MIN + 5, 1'b0, cap);
    check("wrap_chk", 64'(cap[7:0]), 64'h00);
    run_frame(8'hFF, 8'hFF, 8'hFF, 8'h03, 1'b1, START_MIN + 5, 1'b0, cap);
    check("inject_chk", 64'(cap[7:0]), 64'h01);

    // One cycle too short: only a short_start pulse.
    host_low(START_MIN - 1);
    push_n(4'b0000, 3);
    push_n(4'b0001, 1);
    dat_i = 1'b1;
    repeat (20) @(posedge clk);

    // Long hold saturates the low counter and still yields a normal frame.
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0,
              3 * START_MIN, 1'b0, cap);

    // Line and payload churn during the frame must not disturb it.
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0,
              START_MIN + 10, 1'b1, cap);

    for (int k = 0; k < 3; k++)
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), START_MIN + int'($urandom_range(0, 200)), 1'b0, cap);

    // Asynchronous reset during bit 17.
    humid_int = 8'($urandom); humid_dec = 8'($urandom);
    temp_int = 8'($urandom); temp_dec = 8'($urandom);
    runs.delete();
    host_low(START_MIN);
    push_frame(humid_int, humid_dec, temp_int, temp_dec, 1'b0);
    dat_i = 1'b1;
    for (int i = 0; i < 6000 && runs.size() < 19; i++) @(negedge clk);
    check("reached_bit17", 64'(runs.size() >= 19), 64'd1);
    check("bit17_low_phase", 64'(dat_oe), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midframe_rst_dat_oe", 64'(dat_oe), 64'd0);
    check("midframe_rst_busy", 64'(busy), 64'd0);
    check("midframe_rst_state", 64'(state_dbg), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0,
              START_MIN, 1'b0, cap);

    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
